sd_image_writer: RTL
====================

# sd_image_writer

Byte-stream-to-word packer and write master that sits directly upstream of the loader's 32-bit single-port on-chip memory. It accepts bytes from the SD card sector reader over a valid/ready handshake, packs them little-endian into 32-bit words, and issues single-cycle writes with byte enables into the memory. Transfer start, base word address and length come from the loader's control logic. Completion is reported with a `done` pulse, or with an `error` flag if the transfer would pass the memory end.

## Interface
- `ADDR_W`, 15, memory word-address width.
- `MEM_WORDS`, 24576, number of valid words; word addresses >= MEM_WORDS are out of range.
- `LEN_W`, 17, byte-length width; the maximum image is 98304 bytes.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address; sampled with `start`.
- `length`  in  LEN_W  byte count; sampled with `start`.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a byte this cycle.
- `mem_address`  out  ADDR_W  memory word address.
- `mem_byteenable`  out  4  byte lanes being written.
- `mem_chipselect`  out  1  asserted with `mem_write`.
- `mem_write`  out  1  single-cycle write strobe; the memory has no wait state.
- `mem_writedata`  out  32  packed word.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky out-of-range flag; cleared by the next accepted `start`.
- `checksum`  out  16  running byte sum (see Configuration).

## Operation
- **States:** IDLE, FILL, WRITE, DONE.
- **IDLE:**
  - On `start`: latch `base_addr` into the word pointer and `length` into the remaining count, clear the lane index, the data register, `error` and `checksum`.
  - If `length`==0, go to DONE.
  - Else if `base_addr` >= MEM_WORDS, set `error` and go to DONE.
  - Else go to FILL.
- **FILL:**
  - `in_ready`=1. Each byte is accepted when `in_valid & in_ready`.
  - An accepted byte is stored in lane `idx` (bits `8*idx+7:8*idx`), sets byteenable bit `idx`, increments `idx` and decrements the remaining count.
  - Go to WRITE when `idx` reaches 4 or the remaining count reaches 0.
- **WRITE:**
  - `in_ready`=0. Drive `mem_write`=`mem_chipselect`=1 for exactly one cycle, with the accumulated byteenable, data and pointer.
  - After the write: increment the pointer and clear `idx` and the byteenable.
  - If the remaining count is 0, go to DONE.
  - Else if the new pointer is >= MEM_WORDS, set `error` and go to DONE.
  - Else return to FILL.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- Unwritten lanes of a partial final word have byteenable=0; their data is 0.
- `start` is ignored while `busy`. Bytes presented while `in_ready`=0 are not consumed.
- The pointer arithmetic is ADDR_W+1 bits wide, so the comparison against MEM_WORDS cannot wrap.

## Timing
- **Reset values:**
  - `in_ready`=0, `mem_write`=0, `mem_chipselect`=0.
  - `mem_address`=0, `mem_byteenable`=0, `mem_writedata`=0.
  - `busy`=0, `done`=0, `error`=0, `checksum`=0.
  - State is IDLE.
- All outputs are registered except `in_ready`, which is decoded from the state register.
- **Latency and throughput:**
  - `start` to the first `in_ready`=1 is 1 cycle.
  - The 4th byte of a word is accepted in cycle N; `mem_write` is high in cycle N+1; `in_ready` returns in N+2.
  - Peak throughput is 4 bytes per 5 cycles.
- The last write is followed by `done` in the next cycle. For `length`=0, `done` comes 1 cycle after `start`.
- **Reset mid-transfer:** abandons the transfer with no further writes and returns all outputs to their reset values. Partially packed bytes are discarded.

## Configuration
- `SD_IMAGE_WRITER_CHECKSUM_EN` defined:
  - `checksum` is the 16-bit modulo-2^16 sum of every accepted byte.
  - It is updated on acceptance and holds its value through DONE and IDLE until the next `start`.
- Undefined: `checksum` is tied to 0 and no adder is synthesized.

## Test plan
- **Aligned transfer:** `base_addr`=0x0100, `length`=8, bytes 01..08 with `in_valid` held high.
  - Writes 0x04030201 at 0x0100 and 0x08070605 at 0x0101, both with byteenable 4'hF.
  - `done` 1 cycle after the second write; `checksum`=0x0024 with the macro, 0 without.
- **Partial tail:** `length`=6, bytes AA BB CC DD EE FF.
  - Second write is 0x0000FFEE with byteenable 4'h3.
- **Backpressure and gaps:** toggle `in_valid` randomly over a 512-byte sector.
  - Exactly 128 writes at consecutive addresses; no byte lost or duplicated; `in_ready` is low in every WRITE cycle.
- **Boundary:** `base_addr`=24574, `length`=12.
  - Writes land at 24574 and 24575 only, then `error`=1 and a `done` pulse.
  - Separately, `base_addr`=24576 gives no write and `error`=1.
- **Zero length and ignored start:**
  - `length`=0 gives `done` at start+1 with no write.
  - `start` pulsed while `busy` has no effect on the ongoing transfer.
- **Reset mid-transfer:** assert `reset_n`=0 after 3 bytes of a word.
  - No write is issued and all outputs take their reset values.
  - A fresh transfer afterwards completes correctly.

Source files
------------

// File: rtl/sd_image_writer.sv
`timescale 1ns/1ps
// sd_image_writer: packs a byte stream little-endian into 32-bit words and writes them to on-chip memory.
// Optional running byte checksum enabled by defining SD_IMAGE_WRITER_CHECKSUM_EN.
module sd_image_writer #(
  parameter int ADDR_W    = 15,
  parameter int MEM_WORDS = 24576,
  parameter int LEN_W     = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       checksum
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  // One extra pointer bit so the end-of-memory compare cannot wrap.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   ptr, ptr_inc;
  logic [LEN_W-1:0]  remaining;
  logic [1:0]        idx;
  logic [31:0]       data_acc, data_nxt;
  logic [3:0]        be_acc, be_nxt;
  logic              start_ok, accept, launch, set_error;

  assign in_ready = (state == FILL);
  assign ptr_inc  = ptr + (ADDR_W+1)'(1);
  assign data_nxt = data_acc | ({24'b0, in_data} << {idx, 3'b000});
  assign be_nxt   = be_acc | (4'b0001 << idx);
  assign launch   = accept && (state_nxt == WRITE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_nxt = state;
    start_ok  = 1'b0;
    accept    = 1'b0;
    set_error = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          if (length == '0) begin
            state_nxt = DONE;
          end else if ({1'b0, base_addr} >= MEM_LIMIT) begin
            set_error = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = FILL;
          end
        end
      end
      FILL: begin
        if (in_valid) begin
          accept = 1'b1;
          if (idx == 2'd3 || remaining == LEN_W'(1)) state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (remaining == '0) begin
          state_nxt = DONE;
        end else if (ptr_inc >= MEM_LIMIT) begin
          set_error = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = FILL;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr            <= '0;
      remaining      <= '0;
      idx            <= '0;
      data_acc       <= '0;
      be_acc         <= '0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in the same block.
      mem_write      <= 1'b0;
      mem_chipselect <= 1'b0;
      done           <= (state_nxt == DONE);
      busy           <= (state_nxt != IDLE);

      if (start_ok) begin
        ptr       <= {1'b0, base_addr};
        remaining <= length;
        idx       <= '0;
        data_acc  <= '0;
        be_acc    <= '0;
        error     <= set_error;
      end else if (set_error) begin
        error <= 1'b1;
      end

      if (accept) begin
        data_acc  <= data_nxt;
        be_acc    <= be_nxt;
        idx       <= idx + 2'd1;
        remaining <= remaining - LEN_W'(1);
      end

      // The word is registered onto the memory bus as its last byte arrives.
      if (launch) begin
        mem_write      <= 1'b1;
        mem_chipselect <= 1'b1;
        mem_address    <= ptr[ADDR_W-1:0];
        mem_writedata  <= data_nxt;
        mem_byteenable <= be_nxt;
      end

      if (state == WRITE) begin
        ptr            <= ptr_inc;
        idx            <= '0;
        data_acc       <= '0;
        be_acc         <= '0;
        mem_byteenable <= '0;
      end
    end
  end

`ifdef SD_IMAGE_WRITER_CHECKSUM_EN
  logic [15:0] sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      sum <= '0;
    else if (start_ok) sum <= '0;
    else if (accept)   sum <= sum + {8'b0, in_data};
  end

  assign checksum = sum;
`else
  assign checksum = 16'h0000;
`endif

endmodule
